// File: rtl/team_06_audio_pkg.sv
// Shared audio-path definitions for the ADC-to-I2S transmit chain.
package team_06_audio_pkg;

    localparam int unsigned SAMPLE_W_DEFAULT = 8;
    localparam int unsigned I2S_SLOT_W       = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // Mask with only bit (w-1) set; XOR with it flips offset-binary to two's complement.
    function automatic logic [31:0] msb_mask(input int unsigned w);
        return 32'(1) << (w - 1);
    endfunction

    localparam logic [SAMPLE_W_DEFAULT-1:0] OFFSET_MSB_MASK =
        SAMPLE_W_DEFAULT'(msb_mask(SAMPLE_W_DEFAULT));

endpackage

// File: rtl/team_06_sample_fifo.sv
// Two-entry synchronous sample FIFO with registered status flags and overflow pulse.
module team_06_sample_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_c,
    output logic         empty,
    output logic         ready,
    output logic         overflow
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_n;
    logic         rd_ptr_q, rd_ptr_n;
    logic [1:0]   count_q, count_n;
    logic         full_q, full_n;
    logic         empty_q, empty_n;
    logic         ready_q, ready_n;
    logic         overflow_q, overflow_n;
    logic         do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push while full still lands.
    always_comb begin
        do_pop     = pop && !empty_q;
        do_push    = push && (!full_q || do_pop);
        wr_ptr_n   = wr_ptr_q ^ do_push;
        rd_ptr_n   = rd_ptr_q ^ do_pop;
        count_n    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_n = count_q + 2'd1;
            2'b01:   count_n = count_q - 2'd1;
            default: count_n = count_q;
        endcase
        full_n     = (count_n == 2'd2);
        empty_n    = (count_n == 2'd0);
        ready_n    = !full_n;
        overflow_n = push && full_q && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            count_q    <= count_n;
            full_q     <= full_n;
            empty_q    <= empty_n;
            ready_q    <= ready_n;
            overflow_q <= overflow_n;
        end
    end

    assign head_c   = mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign ready    = ready_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/team_06_i2s_tx.sv
// I2S (Philips) transmitter: buffers mono ADC samples and sends each in both slots, MSB first.
module team_06_i2s_tx
    import team_06_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEFAULT,
    parameter int unsigned SLOT_W      = I2S_SLOT_W,
    parameter int unsigned BCLK_DIV    = 4,
    parameter int unsigned OFFSET_CONV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sd,
    output logic                underrun,
    output logic                overflow
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_W;
    localparam int unsigned B_W        = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0]    DIV_MAX   = DIV_W'(BCLK_DIV - 1);
    localparam logic [B_W-1:0]      B_LAST    = B_W'(FRAME_BITS - 1);
    localparam logic [B_W-1:0]      B_SLOT    = B_W'(SLOT_W);
    localparam logic [B_W-1:0]      LR_LO     = B_W'(SLOT_W - 1);
    localparam logic [B_W-1:0]      LR_HI     = B_W'(FRAME_BITS - 2);
    localparam logic [SAMPLE_W-1:0] CONV_MASK =
        (OFFSET_CONV != 0) ? SAMPLE_W'(msb_mask(SAMPLE_W)) : '0;

    logic [DIV_W-1:0]    div_q, div_n;
    logic                bclk_q, bclk_n;
    logic [B_W-1:0]      b_q, b_n;
    logic [SAMPLE_W-1:0] word_q, word_n;
    logic                lrclk_q, lrclk_n;
    logic                sd_q, sd_n;
    logic                underrun_q, underrun_n;
    logic                pop_c;
    channel_e            ch_n;
    logic [B_W-1:0]      slot_pos;
    logic [SAMPLE_W-1:0] shifted;

    logic [SAMPLE_W-1:0] fifo_head_c;
    logic                fifo_empty;
    logic                fifo_ready;
    logic                fifo_overflow;

    team_06_sample_fifo #(
        .W(SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_valid),
        .push_data (sample_in ^ CONV_MASK),
        .pop       (pop_c),
        .head_c    (fifo_head_c),
        .empty     (fifo_empty),
        .ready     (fifo_ready),
        .overflow  (fifo_overflow)
    );

    // Divider, bit counter and serializer; everything but the divider moves only on BCLK falls.
    always_comb begin
        div_n      = div_q;
        bclk_n     = bclk_q;
        b_n        = b_q;
        word_n     = word_q;
        lrclk_n    = lrclk_q;
        sd_n       = sd_q;
        underrun_n = 1'b0;
        pop_c      = 1'b0;
        ch_n       = CH_LEFT;
        slot_pos   = '0;
        shifted    = '0;

        if (div_q == DIV_MAX) begin
            div_n  = '0;
            bclk_n = ~bclk_q;
            if (bclk_q) begin
                b_n = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
                if (b_n == '0) begin
                    if (!fifo_empty) begin
                        pop_c  = 1'b1;
                        word_n = fifo_head_c;
                    end else begin
                        underrun_n = 1'b1;
                    end
                end
                // LRCLK leads each slot by one bit, as I2S requires.
                ch_n     = (b_n >= LR_LO && b_n <= LR_HI) ? CH_RIGHT : CH_LEFT;
                lrclk_n  = (ch_n == CH_RIGHT);
                slot_pos = (b_n >= B_SLOT) ? b_n - B_SLOT : b_n;
                shifted  = word_n << slot_pos;
                sd_n     = shifted[SAMPLE_W-1];
            end
        end else begin
            div_n = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            b_q        <= B_LAST;
            word_q     <= '0;
            lrclk_q    <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_n;
            bclk_q     <= bclk_n;
            b_q        <= b_n;
            word_q     <= word_n;
            lrclk_q    <= lrclk_n;
            sd_q       <= sd_n;
            underrun_q <= underrun_n;
        end
    end

    assign sample_ready = fifo_ready;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sd       = sd_q;
    assign underrun     = underrun_q;
    assign overflow     = fifo_overflow;

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Scoreboard bench for team_06_i2s_tx: dut0 converts offset-binary, dut1 passes samples through.
module tb_team_06_i2s_tx;

    typedef struct packed {
        logic [7:0] w;
        logic       ur;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sin0 = 8'h00;
    logic [7:0] sin1 = 8'h00;
    logic [1:0] valid = 2'b00;
    logic [1:0] ready, bclk, lrclk, sd, ur, ovf;

    int checks = 0;
    int failures = 0;

    frame_t exp_q0[$];
    frame_t exp_q1[$];

    team_06_i2s_tx #(.SAMPLE_W(8), .SLOT_W(16), .BCLK_DIV(2), .OFFSET_CONV(1)) dut0 (
        .clk(clk), .rst(rst), .sample_in(sin0), .sample_valid(valid[0]),
        .sample_ready(ready[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]),
        .i2s_sd(sd[0]), .underrun(ur[0]), .overflow(ovf[0])
    );

    team_06_i2s_tx #(.SAMPLE_W(8), .SLOT_W(16), .BCLK_DIV(2), .OFFSET_CONV(0)) dut1 (
        .clk(clk), .rst(rst), .sample_in(sin1), .sample_valid(valid[1]),
        .sample_ready(ready[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]),
        .i2s_sd(sd[1]), .underrun(ur[1]), .overflow(ovf[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input int idx, input logic [7:0] w, input logic u);
        frame_t f;
        f.w  = w;
        f.ur = u;
        if (idx == 0) exp_q0.push_back(f);
        else          exp_q1.push_back(f);
    endtask

    // Monitor state, one slot per DUT.
    int          m_b   [2];
    bit          m_in  [2];
    bit          m_first[2];
    int          m_cnt [2];
    logic        m_prev[2];
    logic [31:0] m_sd  [2];
    logic [31:0] m_lr  [2];
    int          m_ur  [2];
    bit          m_fall;
    bit          m_has;
    frame_t      m_e;

    // Reconstruct frames from bus activity and score them against queued expectations.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_b[i]     = 31;
                m_in[i]    = 1'b0;
                m_first[i] = 1'b1;
                m_cnt[i]   = 0;
                m_prev[i]  = 1'b0;
            end else begin
                m_fall = m_prev[i] && !bclk[i];
                if (m_fall) begin
                    if (m_first[i]) begin
                        check($sformatf("d%0d_first_fall_delay", i), 32'(m_cnt[i]), 32'd4);
                        m_first[i] = 1'b0;
                    end
                    m_b[i] = (m_b[i] == 31) ? 0 : m_b[i] + 1;
                    if (m_b[i] == 0) begin
                        m_in[i] = 1'b1;
                        m_sd[i] = '0;
                        m_lr[i] = '0;
                        m_ur[i] = 0;
                    end
                    if (m_in[i]) begin
                        m_sd[i] = {m_sd[i][30:0], sd[i]};
                        m_lr[i] = {m_lr[i][30:0], lrclk[i]};
                    end
                end
                if (m_in[i] && ur[i]) m_ur[i]++;
                if (m_fall && m_in[i] && m_b[i] == 31) begin
                    m_has = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                    if (!m_has) begin
                        check($sformatf("d%0d_frame_unexpected", i), m_sd[i], 32'hDEAD_BEEF);
                    end else begin
                        m_e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("d%0d_frame_sd", i), m_sd[i],
                              {m_e.w, 8'h00, m_e.w, 8'h00});
                        check($sformatf("d%0d_frame_lrclk", i), m_lr[i], 32'h0001_FFFE);
                        check($sformatf("d%0d_frame_underrun", i), 32'(m_ur[i]), 32'(m_e.ur));
                    end
                    m_in[i] = 1'b0;
                end
                m_cnt[i]++;
                m_prev[i] = bclk[i];
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_bclk",     32'(bclk),  32'd0);
        check("rst_lrclk",    32'(lrclk), 32'd0);
        check("rst_sd",       32'(sd),    32'd0);
        check("rst_underrun", 32'(ur),    32'd0);
        check("rst_overflow", 32'(ovf),   32'd0);
        check("rst_ready",    32'(ready), 32'd3);
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b);
        valid = v;
        sin0  = a;
        sin1  = b;
        @(posedge clk); #1;
        valid = 2'b00;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            @(posedge clk);
        end
        check("drain_timeout", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    initial begin
        // Idle: silence with one underrun per frame.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            expect_frame(0, 8'h00, 1'b1);
            expect_frame(1, 8'h00, 1'b1);
        end
        wait_drain();

        // Single sample before the first frame, then repeated with underrun.
        do_reset();
        expect_frame(0, 8'h27, 1'b0);
        expect_frame(0, 8'h27, 1'b1);
        expect_frame(1, 8'h80, 1'b0);
        expect_frame(1, 8'h80, 1'b1);
        push(2'b11, 8'hA7, 8'h80);
        wait_drain();

        // Three back-to-back pushes: the third overflows.
        do_reset();
        expect_frame(0, 8'h27, 1'b0);
        expect_frame(0, 8'h56, 1'b0);
        expect_frame(0, 8'h56, 1'b1);
        for (int f = 0; f < 3; f++) expect_frame(1, 8'h00, 1'b1);
        push(2'b01, 8'hA7, 8'h00);
        push(2'b01, 8'hD6, 8'h00);
        check("full_ready", 32'(ready), 32'd2);
        push(2'b01, 8'h11, 8'h00);
        check("overflow_pulse", 32'(ovf), 32'd1);
        @(posedge clk); #1;
        check("overflow_clear", 32'(ovf), 32'd0);
        check("ready_after_pop", 32'(ready), 32'd3);
        wait_drain();

        // Push coinciding with the b=0 pop on an empty FIFO lands in the next frame.
        do_reset();
        expect_frame(0, 8'h00, 1'b1);
        expect_frame(0, 8'h00, 1'b0);
        expect_frame(0, 8'h00, 1'b1);
        expect_frame(1, 8'h00, 1'b1);
        expect_frame(1, 8'h80, 1'b0);
        expect_frame(1, 8'h80, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        push(2'b11, 8'h80, 8'h80);
        check("same_cycle_underrun", 32'(ur), 32'd3);
        wait_drain();

        // Mid-frame reset with two entries queued flushes everything.
        do_reset();
        push(2'b11, 8'hA7, 8'hA7);
        push(2'b11, 8'hD6, 8'hD6);
        repeat (7) @(posedge clk);
        #1;
        push(2'b11, 8'h11, 8'h11);
        check("two_queued_ready", 32'(ready), 32'd0);
        repeat (73) @(posedge clk);
        do_reset();
        for (int f = 0; f < 2; f++) begin
            expect_frame(0, 8'h00, 1'b1);
            expect_frame(1, 8'h00, 1'b1);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
